// File: rtl/pcm_stream_fifo.sv
// pcm_stream_fifo
//
// Buffers the PCM stream that data_io delivers from the HDD/CD channel and
// feeds the audio mixer with one multi-channel frame per sample-rate enable.
// Host words go into a dual-port RAM. Output stays muted (zero frames) until
// the buffer holds START_LEVEL words. From then on, each cen_sample pops
// CHANNELS words and presents them together as one frame on sample_out.
//
// Ports
//   clk_sys       system clock
//   reset         synchronous active-high reset; also clears the sticky status
//   clk_en        qualifies hdd_cdda_wr
//   cen_sample    one-cycle sample-rate enable
//   flush         synchronous clear of buffer contents; status is kept
//   pause         emit zero frames without consuming data
//   hdd_cdda_req  room for at least one more SECTOR_WORDS block
//   hdd_cdda_wr   host write strobe
//   hdd_data_out  host write data
//   sample_out    frame; channel k occupies bits [16k+15:16k]
//   sample_valid  one-cycle pulse whenever sample_out is reloaded
//   level         number of words currently stored
//   active        high while streaming (RUN or FETCH)
//   overflow      sticky; set when a write arrives while the buffer is full
//   underrun_cnt  saturating count of underruns
//
// state  | meaning
// IDLE   | prefill; zero frames on cen_sample until used >= START_LEVEL
// RUN    | streaming; cen_sample starts a fetch, or emits a pause/underrun zero frame
// FETCH  | popping CHANNELS words, then loading the assembled frame

module pcm_stream_fifo #(
    parameter int FIFO_DEPTH   = 12,
    parameter int CHANNELS     = 2,
    parameter int SECTOR_WORDS = 1176,
    parameter int START_LEVEL  = 1176,
    parameter int BYTE_SWAP    = 1
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    cen_sample,
    input  logic                    flush,
    input  logic                    pause,
    output logic                    hdd_cdda_req,
    input  logic                    hdd_cdda_wr,
    input  logic [15:0]             hdd_data_out,
    output logic [16*CHANNELS-1:0]  sample_out,
    output logic                    sample_valid,
    output logic [FIFO_DEPTH:0]     level,
    output logic                    active,
    output logic                    overflow,
    output logic [7:0]              underrun_cnt
);

    localparam int WORDS = 1 << FIFO_DEPTH;
    localparam int CW    = $clog2(CHANNELS + 1);

    localparam logic [FIFO_DEPTH:0] FULL      = (FIFO_DEPTH+1)'(WORDS);
    localparam logic [FIFO_DEPTH:0] REQ_LIM   = (FIFO_DEPTH+1)'(WORDS - SECTOR_WORDS);
    localparam logic [FIFO_DEPTH:0] START_LVL = (FIFO_DEPTH+1)'(START_LEVEL);
    localparam logic [FIFO_DEPTH:0] CH_LVL    = (FIFO_DEPTH+1)'(CHANNELS);
    localparam logic [CW-1:0]       CH_CNT    = CW'(CHANNELS);
    localparam logic [CW-1:0]       LAST_LANE = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FETCH = 2'd2
    } state_t;

    state_t                 state;
    logic [15:0]            mem [WORDS];
    logic [FIFO_DEPTH-1:0]  inptr;
    logic [FIFO_DEPTH-1:0]  outptr;
    logic [FIFO_DEPTH:0]    used;
    logic [15:0]            wr_word;
    logic [15:0]            rd_word;
    logic                   wr_req;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          fetch_cnt;
    logic [CW-1:0]          cap_lane;
    logic [15:0]            shadow [CHANNELS];
    logic [16*CHANNELS-1:0] frame_next;

    assign wr_word = (BYTE_SWAP != 0) ? {hdd_data_out[7:0], hdd_data_out[15:8]}
                                      : hdd_data_out;
    assign wr_req  = clk_en & hdd_cdda_wr;
    assign full    = (used == FULL);
    // A write in the same cycle as flush or reset is dropped.
    assign push    = wr_req & ~full & ~flush & ~reset;
    // fetch_cnt counts down from CHANNELS; one read is issued per nonzero count.
    assign pop     = (state == S_FETCH) && (fetch_cnt != '0);

    assign hdd_cdda_req = (used <= REQ_LIM);
    assign level        = used;
    assign active       = (state != S_IDLE);

    // RAM read data lags the pop by one clock. So with count c (< CHANNELS)
    // the word on rd_word belongs to lane CHANNELS-1-c.
    assign cap_lane = LAST_LANE - fetch_cnt;

    // The last lane is taken straight from the RAM output. The frame can then
    // be loaded in the same cycle that word arrives.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (k == CHANNELS - 1)
                frame_next[16*k +: 16] = rd_word;
            else
                frame_next[16*k +: 16] = shadow[k];
        end
    end

    // Storage: this RAM has no reset, and it always reads at outptr.
    always_ff @(posedge clk_sys) begin
        if (push)
            mem[inptr] <= wr_word;
        rd_word <= mem[outptr];
    end

    // Lanes are overwritten in every frame before they are used, so the
    // shadow register needs no reset.
    always_ff @(posedge clk_sys) begin
        if (state == S_FETCH && fetch_cnt != CH_CNT) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (cap_lane == CW'(k))
                    shadow[k] <= rd_word;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            inptr  <= '0;
            outptr <= '0;
            used   <= '0;
        end else begin
            if (push)
                inptr <= inptr + 1'b1;
            if (pop)
                outptr <= outptr + 1'b1;
            case ({push, pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            overflow <= 1'b0;
        else if (wr_req && full && !flush)
            overflow <= 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            state        <= S_IDLE;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            fetch_cnt    <= '0;
            if (reset)
                underrun_cnt <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cen_sample) begin
                        sample_out   <= '0;
                        sample_valid <= 1'b1;
                    end
                    if (used >= START_LVL)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (cen_sample) begin
                        if (pause) begin
                            sample_out   <= '0;
                            sample_valid <= 1'b1;
                        end else if (used >= CH_LVL) begin
                            fetch_cnt <= CH_CNT;
                            state     <= S_FETCH;
                        end else begin
                            sample_out   <= '0;
                            sample_valid <= 1'b1;
                            state        <= S_IDLE;
                            if (underrun_cnt != 8'hFF)
                                underrun_cnt <= underrun_cnt + 8'd1;
                        end
                    end
                end
                S_FETCH: begin
                    // cen_sample is ignored here. Frames always complete,
                    // because the word count was checked on entry.
                    if (fetch_cnt != '0) begin
                        fetch_cnt <= fetch_cnt - 1'b1;
                    end else begin
                        sample_out   <= frame_next;
                        sample_valid <= 1'b1;
                        state        <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
